// File: rtl/rr_arb7_pipe_if.sv
// ---------------------------------------------------------------------------
// rr_arb7_pipe_if
//   Handshake bundle between 7 valid/ready requesters, the round-robin
//   arbiter/register stage, and its single downstream consumer.
//   Signals:
//     req_valid [6:0]        requester i has data
//     req_data  [7*WIDTH-1:0] requester i payload at [i*WIDTH +: WIDTH]
//     req_ready [6:0]        requester i accepted this cycle (one-hot or zero)
//     out_valid              output register holds a payload
//     out_data  [WIDTH-1:0]  registered payload
//     out_src   [2:0]        requester index that supplied out_data
//     out_ready              consumer takes out_data this cycle
//   Modports:
//     master : requester/consumer side (drives req_*, out_ready)
//     slave  : arbiter side
// ---------------------------------------------------------------------------
interface rr_arb7_pipe_if #(
  parameter int WIDTH = 32
);
  logic [6:0]         req_valid;
  logic [7*WIDTH-1:0] req_data;
  logic [6:0]         req_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [2:0]         out_src;
  logic               out_ready;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/rr_arb7_pipe.sv
// ---------------------------------------------------------------------------
// rr_arb7_pipe
//   Round-robin arbiter for 7 valid/ready requesters followed by a single
//   output register. The granted requester's payload is captured together
//   with its index, so the muxed data path is isolated from the consumer.
//   Ports:
//     clk    clock, all state on the rising edge
//     rst_n  asynchronous active-low reset
//     bus    rr_arb7_pipe_if.slave (request side + output side)
//
//   state | meaning
//   ------+-------------------------------------------
//   EMPTY | output register empty, out_valid = 0
//   FULL  | output register holds a payload, out_valid = 1
// ---------------------------------------------------------------------------
module rr_arb7_pipe #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_arb7_pipe_if.slave  bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [2:0]       r_src;
  logic [2:0]       r_rr_ptr;

  logic             w_any;
  logic             w_ld;
  logic             w_accept;
  logic [2:0]       w_gnt;
  logic             w_found;
  logic [2:0]       w_ptr_nxt;
  logic [WIDTH-1:0] w_sel_data;

  assign w_any    = |bus.req_valid;
  assign w_ld     = (r_state == EMPTY) | bus.out_ready;
  assign w_accept = w_ld & w_any;

  // Search from r_rr_ptr upward, wrapping 6 -> 0; first valid wins.
  always_comb begin
    logic [3:0] idx;
    w_gnt   = 3'd0;
    w_found = 1'b0;
    idx     = 4'd0;
    for (int k = 0; k < 7; k++) begin
      idx = {1'b0, r_rr_ptr} + 4'(k);
      if (idx > 4'd6) idx = idx - 4'd7;
      if (!w_found && bus.req_valid[idx[2:0]]) begin
        w_gnt   = idx[2:0];
        w_found = 1'b1;
      end
    end
  end

  // 7:1 payload mux; index 7 never selected.
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < 7; k++) begin
      if (w_gnt == 3'(k)) w_sel_data = bus.req_data[k*WIDTH +: WIDTH];
    end
  end

  assign w_ptr_nxt = (w_gnt == 3'd6) ? 3'd0 : w_gnt + 3'd1;

  // Gated by rst_n so nothing is acked while reset is asserted.
  assign bus.req_ready = (rst_n && w_accept) ? 7'(8'b1 << w_gnt) : 7'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= EMPTY;
      r_data   <= '0;
      r_src    <= 3'd0;
      r_rr_ptr <= 3'd0;
    end else begin
      case (r_state)
        EMPTY: if (w_any) r_state <= FULL;
        FULL:  if (bus.out_ready && !w_any) r_state <= EMPTY;
      endcase
      if (w_accept) begin
        r_data   <= w_sel_data;
        r_src    <= w_gnt;
        r_rr_ptr <= w_ptr_nxt;
      end
    end
  end

  assign bus.out_valid = (r_state == FULL);
  assign bus.out_data  = r_data;
  assign bus.out_src   = r_src;

endmodule

// File: tb/tb_rr_arb7_pipe.sv
// ---------------------------------------------------------------------------
// tb_rr_arb7_pipe
//   Self-checking bench: directed scenarios with literal expectations, then
//   randomized traffic checked every cycle against a priority-queue model.
// ---------------------------------------------------------------------------
module tb_rr_arb7_pipe;
  localparam int W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_arb7_pipe_if #(.WIDTH(W)) bus ();

  rr_arb7_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: priority order kept as a queue; front = highest priority.
  bit         m_valid;
  logic [W-1:0] m_data;
  int         m_src;
  int         prio[$];
  int         m_last_gnt;

  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_src   = 0;
    prio.delete();
    for (int i = 0; i < 7; i++) prio.push_back(i);
    m_last_gnt = -1;
  endfunction

  // One clock: compare at negedge, advance the model just after posedge.
  task automatic cycle();
    int           e_gnt;
    bit           e_acc;
    bit           e_drain;
    bit           in_rst;
    logic [6:0]   e_ready;
    logic [W-1:0] e_dat;
    @(negedge clk);
    e_gnt = -1;
    foreach (prio[k]) if (e_gnt < 0 && bus.req_valid[prio[k]]) e_gnt = prio[k];
    e_acc   = rst_n && (!m_valid || bus.out_ready) && (e_gnt >= 0);
    e_drain = m_valid && bus.out_ready;
    e_ready = e_acc ? 7'(1 << e_gnt) : 7'd0;
    e_dat   = e_acc ? bus.req_data[e_gnt*W +: W] : '0;
    chk("onehot0", 64'($onehot0(bus.req_ready)), 64'd1);
    chk("src_range", 64'(bus.out_src <= 3'd6), 64'd1);
    if (!rst_n) begin
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_src", bus.out_src, 0);
      chk("rst_out_data", bus.out_data, 0);
    end else begin
      chk("req_ready", bus.req_ready, e_ready);
      chk("out_valid", bus.out_valid, m_valid);
      chk("out_src", bus.out_src, m_src);
      chk("out_data", bus.out_data, m_data);
    end
    @(posedge clk);
    in_rst = !rst_n;
    #1;
    m_last_gnt = -1;
    if (in_rst || !rst_n) begin
      model_reset();
    end else if (e_acc) begin
      m_valid    = 1'b1;
      m_data     = e_dat;
      m_src      = e_gnt;
      m_last_gnt = e_gnt;
      while (prio[0] != e_gnt) prio.push_back(prio.pop_front());
      prio.push_back(prio.pop_front());
    end else if (e_drain) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic set_req(int i, bit v, logic [W-1:0] d);
    bus.req_valid[i]       = v;
    bus.req_data[i*W +: W] = d;
  endtask

  int seq3[9] = '{0, 1, 2, 3, 4, 5, 6, 0, 1};

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;
    model_reset();

    // Power-on reset
    repeat (2) cycle();
    chk("por_out_valid", bus.out_valid, 0);
    chk("por_out_src", bus.out_src, 0);
    rst_n = 1'b1;

    // Single source, requester 4
    set_req(4, 1'b1, 'hA5);
    bus.out_ready = 1'b1;
    #1 chk("t2_ready", bus.req_ready, 7'b0010000);
    cycle();
    chk("t2_valid", bus.out_valid, 1);
    chk("t2_data", bus.out_data, 'hA5);
    chk("t2_src", bus.out_src, 4);
    chk("t2_ptr", prio[0], 5);
    set_req(4, 1'b0, 'hA5);

    // Drain, then a late request from 1 is taken immediately
    cycle();
    chk("t6_valid", bus.out_valid, 0);
    chk("t6_src_hold", bus.out_src, 4);
    chk("t6_ptr", prio[0], 5);
    set_req(1, 1'b1, 'h11);
    #1 chk("t6_ready", bus.req_ready, 7'b0000010);
    cycle();
    chk("t6_src", bus.out_src, 1);
    chk("t6_data", bus.out_data, 'h11);

    // Async reset mid-stream while FULL
    for (int i = 0; i < 7; i++) set_req(i, 1'b1, W'('h100 + i));
    #2 rst_n = 1'b0;
    #1;
    chk("t1_out_valid", bus.out_valid, 0);
    chk("t1_out_src", bus.out_src, 0);
    chk("t1_req_ready", bus.req_ready, 0);
    cycle();
    rst_n = 1'b1;

    // All seven valid, continuous out_ready: strict rotation from 0
    bus.out_ready = 1'b1;
    for (int s = 0; s < 9; s++) begin
      cycle();
      chk("t3_valid", bus.out_valid, 1);
      chk("t3_src", bus.out_src, seq3[s]);
      if (m_last_gnt >= 0) set_req(m_last_gnt, 1'b1, W'('h200 + m_last_gnt));
    end

    // Backpressure with out_src = 2
    cycle();
    chk("t5_src", bus.out_src, 2);
    chk("t5_data", bus.out_data, 'h202);
    set_req(2, 1'b1, 'h302);
    bus.out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1 chk("t5_ready_blocked", bus.req_ready, 0);
      cycle();
      chk("t5_src_frozen", bus.out_src, 2);
      chk("t5_data_frozen", bus.out_data, 'h202);
    end
    bus.out_ready = 1'b1;
    #1 chk("t5_ready_resume", bus.req_ready, 7'b0001000);
    cycle();
    chk("t5_src_next", bus.out_src, 3);

    // Wrap: pointer at 6, requests 0 and 2
    bus.req_valid = 7'b0100000;
    cycle();
    chk("t4_ptr6", prio[0], 6);
    bus.req_valid = 7'b0000101;
    #1 chk("t4_ready0", bus.req_ready, 7'b0000001);
    cycle();
    chk("t4_src0", bus.out_src, 0);
    chk("t4_ptr1", prio[0], 1);
    bus.req_valid = 7'b0000100;
    #1 chk("t4_ready2", bus.req_ready, 7'b0000100);
    cycle();
    chk("t4_src2", bus.out_src, 2);
    chk("t4_ptr3", prio[0], 3);

    // Randomized traffic with held requests and occasional reset
    for (int c = 0; c < 3000; c++) begin
      int p;
      p = ((c / 500) % 2 == 1) ? 90 : 40;
      for (int i = 0; i < 7; i++) begin
        if (i == m_last_gnt || !bus.req_valid[i]) begin
          set_req(i, ($urandom_range(99) < p), W'($urandom()));
        end
      end
      bus.out_ready = ($urandom_range(99) < 70);
      rst_n = (c % 500 == 250) ? 1'b0 : 1'b1;
      cycle();
    end
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
